// File: rtl/fib_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : fib_sched_pkg
// Desc   : Shared FSM state encoding and round-robin pick function.
// Rev    : 1.0 - initial release
// ============================================================================
package fib_sched_pkg;

  localparam int c_MAX_REQ = 16;
  localparam int c_PTR_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic hit;
    int   idx;
  } pick_t;

  // Lowest k wins, so the search order is ptr, ptr+1, ... wrapping at num.
  function automatic pick_t rr_pick(input logic [c_MAX_REQ-1:0] valid,
                                    input int ptr, input int num);
    pick_t r;
    int    j;
    r.hit = 1'b0;
    r.idx = 0;
    for (int k = c_MAX_REQ - 1; k >= 0; k--) begin
      j = ptr + k;
      if (j >= num) j = j - num;
      if (k < num && valid[j[c_PTR_W-1:0]]) begin
        r.hit = 1'b1;
        r.idx = j;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fib_iter_core.sv
`default_nettype none
// ============================================================================
// Module : fib_iter_core
// Desc   : Iterative Fibonacci datapath (a/b/cnt/n_lat). Optional overflow
//          flag when FIB_SCHED_OVF_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module fib_iter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] value
`ifdef FIB_SCHED_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] r_a, r_b, r_cnt, r_n_lat;
  logic [WIDTH-1:0] w_sum;

`ifdef FIB_SCHED_OVF_EN
  logic [WIDTH:0] w_sum_ext;
  logic           r_a_ovf, r_b_ovf;

  assign w_sum_ext = {1'b0, r_a} + {1'b0, r_b};
  assign w_sum     = w_sum_ext[WIDTH-1:0];

  // Each lane carries whether its true value has exceeded the word, so the
  // flag reported with the result reflects F(n) itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
    end else if (load) begin
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
    end else if (step) begin
      r_a_ovf <= r_b_ovf;
      r_b_ovf <= r_a_ovf | r_b_ovf | w_sum_ext[WIDTH];
    end
  end

  assign ovf = r_a_ovf;
`else
  assign w_sum = r_a + r_b;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_n_lat <= '0;
    end else if (load) begin
      r_a     <= '0;
      r_b     <= {{(WIDTH-1){1'b0}}, 1'b1};
      r_cnt   <= '0;
      r_n_lat <= n;
    end else if (step) begin
      r_a   <= r_b;
      r_b   <= w_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign done  = (r_cnt == r_n_lat);
  assign value = r_a;

endmodule
`default_nettype wire

// File: rtl/fib_sched.sv
`default_nettype none
// ============================================================================
// Module : fib_sched
// Desc   : Round-robin scheduler sharing one Fibonacci datapath between
//          NUM_REQ requesters. FIB_SCHED_OVF_EN adds the rsp_ovf output.
// Rev    : 1.0 - initial release
// ============================================================================
module fib_sched
  import fib_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_fib,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_idx
`ifdef FIB_SCHED_OVF_EN
  ,
  output logic                     rsp_ovf
`endif
);

  state_t                 r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_rr_ptr, r_grant, w_win, w_ptr_nxt;
  logic [c_MAX_REQ-1:0]   w_valid_ext;
  pick_t                  w_pick;
  logic                   w_load, w_step, w_done;
  logic [WIDTH-1:0]       w_n, w_value;

  always_comb begin
    w_valid_ext                = '0;
    w_valid_ext[NUM_REQ-1:0]   = req_valid;
    w_pick                     = rr_pick(w_valid_ext, int'(r_rr_ptr), NUM_REQ);
  end

  assign w_win     = IDX_W'(w_pick.idx);
  assign w_n       = req_n[w_win*WIDTH +: WIDTH];
  assign w_ptr_nxt = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick.hit) begin
          req_ready[w_win] = 1'b1;
          w_load           = 1'b1;
          w_state_nxt      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_done) w_state_nxt = ST_RESP;
        else        w_step      = 1'b1;
      end
      ST_RESP: begin
        rsp_valid[r_grant] = 1'b1;
        if (rsp_ready[r_grant]) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_grant <= w_win;
      if (r_state == ST_RESP && rsp_ready[r_grant]) r_rr_ptr <= w_ptr_nxt;
    end
  end

  fib_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .step  (w_step),
    .n     (w_n),
    .done  (w_done),
    .value (w_value)
`ifdef FIB_SCHED_OVF_EN
    ,
    .ovf   (rsp_ovf)
`endif
  );

  // The datapath freezes outside RUN, so a holds the result through RESP.
  assign rsp_fib   = w_value;
  assign busy      = (r_state != ST_IDLE);
  assign grant_idx = r_grant;

endmodule
`default_nettype wire
